// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous clear and occupancy count.
// Push and pop may occur in the same cycle, including when full.
// Clear has priority over push and pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == DEPTH_L);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer between the instruction memory port and
// the Fetch->Decode register. Owns the fetch PC, keeps requests in
// flight up to the free queue space, and flushes on a redirect.
// Optional build macro FETCH_BUFFER_BYPASS_EN: a response arriving while
// the queue is empty (and nothing is being dropped) is presented to
// Decode combinationally in the same cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        hlt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        take,
    output logic        validF,
    output logic [31:0] instrF,
    output logic [31:0] pcF
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    fb_state_t   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    // Instruction queue
    fb_entry_t     iq_wdata, iq_rdata;
    logic          iq_push, iq_pop, iq_clr;
    logic          iq_full, iq_empty;
    logic [CW-1:0] iq_count;

    // Pending-PC queue; its occupancy is the outstanding-request count
    logic [31:0]   pq_rdata;
    logic          pq_push, pq_pop;
    logic          pq_full, pq_empty;
    logic [CW-1:0] pq_count;

    logic [CW:0]   inflight;
    logic          space_ok;
    logic          gnt_fire;
    logic          rsp;
    logic          drop_active;
    logic          bypass;
    logic          take_ok;
    fb_entry_t     head;

    sync_fifo #(
        .WIDTH ($bits(fb_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (iq_clr),
        .push  (iq_push),
        .wdata (iq_wdata),
        .pop   (iq_pop),
        .rdata (iq_rdata),
        .full  (iq_full),
        .empty (iq_empty),
        .count (iq_count)
    );

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (1'b0),
        .push  (pq_push),
        .wdata (fetch_pc_q),
        .pop   (pq_pop),
        .rdata (pq_rdata),
        .full  (pq_full),
        .empty (pq_empty),
        .count (pq_count)
    );

    // Request issue, response routing and Decode-facing head selection.
    always_comb begin
        inflight    = {1'b0, iq_count} + {1'b0, pq_count};
        space_ok    = (inflight < DEPTH_L);
        imem_req    = (state_q == RUN) && !redirect && space_ok;
        imem_addr   = fetch_pc_q;
        gnt_fire    = imem_req && imem_gnt;
        rsp         = imem_rvalid;
        drop_active = (drop_cnt_q != '0);
`ifdef FETCH_BUFFER_BYPASS_EN
        bypass      = rsp && !drop_active && iq_empty && !redirect;
`else
        bypass      = 1'b0;
`endif
        iq_wdata    = '{pc: pq_rdata, instr: imem_rdata};
        head        = bypass ? iq_wdata : iq_rdata;
        validF      = !iq_empty || bypass;
        instrF      = validF ? head.instr : NOP_INSTR;
        pcF         = validF ? head.pc : 32'h0000_0000;
        // A redirect kills the head, so a coincident take is meaningless.
        take_ok     = take && validF && !redirect;
        iq_pop      = take_ok && !iq_empty;
        // A bypassed response that Decode takes immediately never lands.
        iq_push     = rsp && !drop_active && !redirect && !(bypass && take_ok);
        iq_clr      = redirect;
        pq_push     = gnt_fire;
        pq_pop      = rsp;
    end

    // Next FSM state, fetch PC and drop counter.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (hlt) state_d = HALT;
            HALT:    if (redirect) state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp && drop_active) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            // Everything still in flight after this cycle's response belongs
            // to the old path.
            drop_cnt_d = pq_count - {{(CW-1){1'b0}}, rsp};
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    a_iq_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(iq_push && iq_full && !iq_pop));

    a_pq_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(pq_push && pq_full && !pq_pop));

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rvalid && pq_empty));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (default build, no bypass).
module tb_fetch_buffer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        hlt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        take = 1'b0;
    logic        validF;
    logic [31:0] instrF;
    logic [31:0] pcF;

    bit gnt_en = 1'b0;
    bit rsp_hold = 1'b0;
    assign imem_gnt = gnt_en;

    int n_cmp = 0;
    int n_bad = 0;
    int pops;
    int grants;
    logic [31:0] exp_pc;
    bit ok;

    fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .hlt         (hlt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .take        (take),
        .validF      (validF),
        .instrF      (instrF),
        .pcF         (pcF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // In-order memory: a grant in cycle k returns data from cycle k+1 on.
    logic [31:0] mq[$];
    bit          m_fire, m_rv;
    logic [31:0] m_addr;
    initial begin
        forever begin
            @(negedge clk);
            m_fire = imem_req && imem_gnt;
            m_addr = imem_addr;
            m_rv   = imem_rvalid;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                mq.delete();
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end else begin
                if (m_rv && mq.size() > 0) void'(mq.pop_front());
                if (m_fire) mq.push_back(m_addr);
                imem_rvalid = !rsp_hold && (mq.size() > 0);
                imem_rdata  = imem_rvalid ? mem_word(mq[0]) : 32'h0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit g, input bit t, input bit hold, input bit check_vals);
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        hlt         = 1'b0;
        take        = t;
        gnt_en      = g;
        rsp_hold    = hold;
        step();
        step();
        if (check_vals) begin
            @(negedge clk);
            chk("reset imem_req", imem_req, 0);
            chk("reset imem_addr", imem_addr, 32'h0);
            chk("reset validF", validF, 0);
            chk("reset instrF", instrF, NOP_INSTR);
            chk("reset pcF", pcF, 32'h0);
        end
        step();
        reset_n = 1'b1;
    endtask

    // Called at a negedge: verify any head entry Decode consumes this cycle.
    task automatic check_pop(input string nm);
        if (validF && take && !redirect) begin
            chk({nm, " pcF"}, pcF, exp_pc);
            chk({nm, " instrF"}, instrF, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
    endtask

    task automatic wait_valid(input string nm, input int maxc, output bit found);
        found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (validF) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: validF not seen within %0d cycles", nm, maxc);
        end
    endtask

    task automatic wait_grants(input string nm, input int n, input int maxc);
        int g;
        g = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) g++;
            if (g >= n) break;
        end
        if (g < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d grants expected %0d", nm, g, n);
        end
    endtask

    typedef struct {
        bit          take;
        bit          hlt;
        bit          redir;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Cycle-by-cycle start-up with a zero-wait memory and take held high,
        // ending with a redirect that coincides with a response (drop_cnt 0).
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b0, 32'h000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h004};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h00C};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h018, 1'b1, 32'h010};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};

        do_reset(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            take        = tbl[i].take;
            hlt         = tbl[i].hlt;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("vec%0d imem_req", i), imem_req, tbl[i].e_req);
            chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d validF", i), validF, tbl[i].e_valid);
            chk($sformatf("vec%0d pcF", i), pcF, tbl[i].e_valid ? tbl[i].e_pc : 32'h0);
            chk($sformatf("vec%0d instrF", i), instrF,
                tbl[i].e_valid ? mem_word(tbl[i].e_pc) : NOP_INSTR);
        end

        // Fill with take low: exactly DEPTH grants, then requests stop.
        do_reset(1'b1, 1'b0, 1'b0, 1'b0);
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            @(negedge clk);
            if (imem_req && imem_gnt) grants++;
        end
        chk("fill grants", grants, 4);
        chk("fill imem_req low", imem_req, 0);
        chk("fill validF", validF, 1);
        chk("fill head pcF", pcF, 32'h0);
        step();
        take   = 1'b1;
        exp_pc = 32'h0;
        pops   = 0;
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_pop("drain");
            if (i >= 1 && i <= 8 && imem_req && imem_gnt) grants++;
            step();
        end
        chk("resume grants", grants, 8);
        chk("drain pops", pops, 10);

        // Asynchronous reset in mid-operation.
        reset_n = 1'b0;
        #1;
        chk("midreset imem_req", imem_req, 0);
        chk("midreset imem_addr", imem_addr, 32'h0);
        chk("midreset validF", validF, 0);
        chk("midreset instrF", instrF, NOP_INSTR);
        chk("midreset pcF", pcF, 32'h0);

        // Three requests outstanding, redirect: late responses discarded.
        do_reset(1'b1, 1'b1, 1'b1, 1'b0);
        wait_grants("B grants", 3, 10);
        step();
        gnt_en = 1'b0;
        @(negedge clk);
        chk("B req with space", imem_req, 1);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        gnt_en      = 1'b1;
        @(negedge clk);
        chk("B req during redirect", imem_req, 0);
        step();
        redirect = 1'b0;
        rsp_hold = 1'b0;
        @(negedge clk);
        chk("B validF after redirect", validF, 0);
        chk("B req after redirect", imem_req, 1);
        chk("B addr after redirect", imem_addr, 32'h100);
        wait_valid("B first valid", 20, ok);
        if (ok) begin
            chk("B first pcF", pcF, 32'h100);
            chk("B first instrF", instrF, mem_word(32'h100));
        end

        // Redirect coinciding with a response and a take.
        do_reset(1'b1, 1'b1, 1'b1, 1'b0);
        wait_grants("C grants", 3, 10);
        step();
        gnt_en = 1'b0;
        step();
        rsp_hold = 1'b0;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        gnt_en      = 1'b1;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("C validF after redirect", validF, 0);
        chk("C req after redirect", imem_req, 1);
        chk("C addr after redirect", imem_addr, 32'h200);
        wait_valid("C first valid", 20, ok);
        if (ok) begin
            chk("C first pcF", pcF, 32'h200);
            chk("C first instrF", instrF, mem_word(32'h200));
        end

        // Halt: grants stop, queue drains, redirect resumes.
        do_reset(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        hlt = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("D halted req%0d", i), imem_req, 0);
            step();
        end
        take   = 1'b1;
        exp_pc = 32'h0;
        pops   = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_pop("D drain");
            step();
        end
        chk("D drain pops", pops, 2);
        @(negedge clk);
        chk("D empty validF", validF, 0);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        hlt         = 1'b0;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("D req after redirect", imem_req, 1);
        chk("D addr after redirect", imem_addr, 32'h40);
        wait_valid("D first valid", 20, ok);
        if (ok) begin
            chk("D first pcF", pcF, 32'h40);
            chk("D first instrF", instrF, mem_word(32'h40));
        end

        // Fetch PC wraps from the top of the address space.
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("E req at top", imem_req, 1);
        chk("E addr at top", imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        chk("E wrap addr", imem_addr, 32'h0000_0000);
        exp_pc = 32'hFFFF_FFFC;
        pops   = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk);
            check_pop("E stream");
        end
        chk("E pops", pops, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch buffer between the instruction-memory port and the Fetch→Decode pipeline register. It owns the fetch PC and issues in-order word requests over a variable-latency grant/response handshake. Returned instructions are queued in a small FIFO and presented to Decode with their PC. On a branch or jump redirect from Execute it discards all queued and in-flight instructions and resumes at the new target.

## Interface
- `DEPTH`, 4: FIFO entries and max outstanding requests combined; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `redirect`  in  1  single-cycle pulse; taken branch or jump in Execute (`pc_srcE | jumpE`).
- `redirect_pc`  in  32  new fetch target; bit 0 already cleared.
- `hlt`  in  1  stop issuing new requests.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  word address of the request.
- `imem_gnt`  in  1  request accepted this cycle when `imem_req & imem_gnt`.
- `imem_rvalid`  in  1  response valid; responses return in order, ≥1 cycle after grant.
- `imem_rdata`  in  32  response instruction.
- `take`  in  1  Decode consumes the head entry (`!stallD`).
- `validF`  out  1  head entry valid.
- `instrF`  out  32  head instruction; NOP (32'h0000_0013) when `!validF`.
- `pcF`  out  32  PC of head instruction; 0 when `!validF`.

## Operation
- FSM with three states:
  - BOOT: one cycle after reset release; no request issued. Goes to RUN.
  - RUN: issues requests. Goes to HALT when `hlt`.
  - HALT: no new requests. Goes to RUN only on `redirect`; queue drain and response collection continue while halted.
- `imem_req` = (state==RUN) & !redirect & (occupancy + outstanding < DEPTH). Counters are `$clog2(DEPTH)+1` bits wide.
- `imem_addr` = fetch PC register. On grant, fetch PC += 4 (wraps modulo 2^32), `outstanding`++, and the request PC is pushed into the pending-PC queue.
- On response, `outstanding`--. If `drop_cnt`==0, push {pending PC, `imem_rdata`} into the FIFO; otherwise discard it and decrement `drop_cnt`.
- On redirect:
  - Clear the FIFO.
  - Fetch PC := `redirect_pc`.
  - `drop_cnt` := outstanding after this cycle's response is retired.
  - A `take` in the same cycle is ignored.
  - Redirect during an active drop recomputes `drop_cnt` the same way.
- Push and pop in the same cycle is always legal. Space accounting guarantees a response never finds the FIFO full; an overflow attempt is an assertion failure.
- `take` while `!validF` is ignored.

## Timing
- Reset values: state BOOT; fetch PC = `RESET_PC`; `imem_req`=0; `imem_addr`=`RESET_PC`; `validF`=0; `instrF`=NOP; `pcF`=0; all counters 0.
- First `imem_req` is asserted in the 2nd cycle after `reset_n` rises.
- Response-to-`validF` latency: 1 cycle (FIFO registered), or 0 cycles with bypass.
- Redirect in cycle N:
  - `validF`=0 in N+1.
  - Request to `redirect_pc` asserted in N+1.
- Reset asserted mid-operation: immediate return to reset values; any later stray `imem_rvalid` is the memory's responsibility (memory reset is assumed shared).

## Configuration
- `FETCH_BUFFER_BYPASS_EN` defined: when the FIFO is empty and `drop_cnt`==0, a response drives `validF`/`instrF`/`pcF` combinationally in the same cycle. If `take` is also set, nothing is written to the FIFO.
- Macro undefined: every response goes through the FIFO; minimum response-to-`validF` latency is 1 cycle.

## Structure
- `fetch_pkg`:
  - `NOP_INSTR` = 32'h0000_0013.
  - FSM state enum `fb_state_t` {BOOT, RUN, HALT}.
  - Entry struct {pc[31:0], instr[31:0]}.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH, synchronous clear, full/empty/count outputs) for the instruction queue.
- A second `sync_fifo` instance (WIDTH=32) holds the pending-PC queue.

## Test plan
- Reset, zero-wait memory (gnt=1, rvalid one cycle later), `take`=1 → `pcF` sequence 0,4,8,12 with matching `instrF`; first `validF` in cycle 3 (2 with bypass).
- `take`=0, `DEPTH`=4 → exactly 4 grants, then `imem_req` held low; releasing `take` resumes requests one per cycle.
- 3 requests outstanding, redirect to 32'h100 → the 3 late responses are discarded; next `pcF`=32'h100.
- Redirect in the same cycle as `imem_rvalid` and `take` → that response is dropped, `drop_cnt`=outstanding−1, `validF`=0 next cycle.
- `hlt` asserted → no new grants; queued entries still drain; redirect to 32'h40 → RUN, fetch from 32'h40.
- Fetch PC 32'hFFFF_FFFC granted → next `imem_addr`=32'h0000_0000.
